// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipelined MIPS control/hazard unit.
// Optional operand forwarding is selected by the PIPE_CTRL_FWD_EN macro.
package pipe_ctrl_pkg;

    localparam int REG_AW   = 5;
    localparam int ALU_OP_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] FWD_REGFILE = 2'd0;
    localparam logic [1:0] FWD_MEMWB   = 2'd1;
    localparam logic [1:0] FWD_EXMEM   = 2'd2;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_AW-1:0] dest;
    } wb_ctrl_t;

    typedef struct packed {
        logic     mem_read;
        logic     mem_write;
        wb_ctrl_t wb;
    } mem_ctrl_t;

    // Full bundle held in ID/EX; later stages keep only the fields they still need.
    typedef struct packed {
        logic                reg_dst;
        logic                alu_src;
        logic [ALU_OP_W-1:0] alu_op;
        logic                branch;
        logic                illegal;
        mem_ctrl_t           mem;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    // True when a valid ID instruction reads the nonzero register dest.
    function automatic logic reads_reg(input logic [REG_AW-1:0] dest,
                                       input logic              valid,
                                       input logic              use_rs,
                                       input logic              use_rt,
                                       input logic [REG_AW-1:0] rs,
                                       input logic [REG_AW-1:0] rt);
        return valid && (dest != '0) &&
               ((use_rs && (dest == rs)) || (use_rt && (dest == rt)));
    endfunction

    function automatic logic [1:0] fwd_sel(input wb_ctrl_t          exmem,
                                           input wb_ctrl_t          memwb,
                                           input logic [REG_AW-1:0] src);
        if (src != '0 && exmem.reg_write && exmem.dest == src)
            return FWD_EXMEM;
        if (src != '0 && memwb.reg_write && memwb.dest == src)
            return FWD_MEMWB;
        return FWD_REGFILE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_main_decoder.sv
// Combinational opcode/funct decoder producing the ID-stage control bundle.
// Unsupported encodings yield a bubble carrying only the illegal flag.
import pipe_ctrl_pkg::*;

module main_decoder (
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    output ctrl_t             bundle,
    output logic              uses_rs,
    output logic              uses_rt
);

    logic bad;

    always_comb begin
        bundle  = BUBBLE;
        uses_rt = 1'b0;
        bad     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                bundle.reg_dst          = 1'b1;
                bundle.mem.wb.reg_write = 1'b1;
                uses_rt                 = 1'b1;
                case (funct)
                    FN_ADD:  bundle.alu_op = ALU_ADD;
                    FN_SUB:  bundle.alu_op = ALU_SUB;
                    FN_AND:  bundle.alu_op = ALU_AND;
                    FN_OR:   bundle.alu_op = ALU_OR;
                    FN_SLT:  bundle.alu_op = ALU_SLT;
                    default: bad = 1'b1;
                endcase
            end
            OP_LW: begin
                bundle.alu_src           = 1'b1;
                bundle.mem.mem_read      = 1'b1;
                bundle.mem.wb.mem_to_reg = 1'b1;
                bundle.mem.wb.reg_write  = 1'b1;
                bundle.alu_op            = ALU_ADD;
            end
            OP_SW: begin
                bundle.alu_src       = 1'b1;
                bundle.mem.mem_write = 1'b1;
                bundle.alu_op        = ALU_ADD;
                uses_rt              = 1'b1;
            end
            OP_BEQ: begin
                bundle.branch = 1'b1;
                bundle.alu_op = ALU_SUB;
                uses_rt       = 1'b1;
            end
            OP_ADDI: begin
                bundle.alu_src          = 1'b1;
                bundle.mem.wb.reg_write = 1'b1;
                bundle.alu_op           = ALU_ADD;
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            bundle         = BUBBLE;
            bundle.illegal = 1'b1;
            uses_rt        = 1'b0;
        end else begin
            bundle.mem.wb.dest = bundle.reg_dst ? rd : rt;
            // r0 is hardwired; writes to it are dropped so nothing forwards from it.
            if (bundle.mem.wb.dest == '0)
                bundle.mem.wb.reg_write = 1'b0;
        end
        uses_rs = !bad;
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined main control + hazard unit: ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall, branch flush. Define PIPE_CTRL_FWD_EN to enable forwarding selects.
import pipe_ctrl_pkg::*;

module pipe_ctrl_unit (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic [REG_AW-1:0]   rs,
    input  logic [REG_AW-1:0]   rt,
    input  logic [REG_AW-1:0]   rd,
    input  logic                ex_zero,
    output logic                ex_reg_dst,
    output logic                ex_alu_src,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                mem_read,
    output logic                mem_write,
    output logic                wb_reg_write,
    output logic                wb_mem_to_reg,
    output logic [REG_AW-1:0]   wb_dest,
    output logic                stall,
    output logic                flush,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic                illegal
);

    ctrl_t     dec;
    ctrl_t     id_ex;
    mem_ctrl_t ex_mem;
    wb_ctrl_t  mem_wb;
    logic      uses_rs;
    logic      uses_rt;
    logic      hit_idex;
    logic      load_use;
    logic      raw_stall;
    logic      take;

    main_decoder u_dec (
        .opcode  (opcode),
        .funct   (funct),
        .rt      (rt),
        .rd      (rd),
        .bundle  (dec),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt)
    );

    always_comb begin
        hit_idex = reads_reg(id_ex.mem.wb.dest, id_valid, uses_rs, uses_rt, rs, rt);
        load_use = id_ex.mem.mem_read && hit_idex;
    end

`ifdef PIPE_CTRL_FWD_EN
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_rs <= '0;
            ex_rt <= '0;
        end else if (take && uses_rs) begin
            ex_rs <= rs;
            ex_rt <= rt;
        end else begin
            ex_rs <= '0;
            ex_rt <= '0;
        end
    end

    always_comb begin
        raw_stall = load_use;
        fwd_a     = fwd_sel(ex_mem.wb, mem_wb, ex_rs);
        fwd_b     = fwd_sel(ex_mem.wb, mem_wb, ex_rt);
    end
`else
    logic hit_exmem;

    // Without forwarding, any in-flight producer in EX or MEM blocks the reader;
    // the register file resolves the MEM/WB case by writing before reading.
    always_comb begin
        hit_exmem = reads_reg(ex_mem.wb.dest, id_valid, uses_rs, uses_rt, rs, rt);
        raw_stall = load_use
                  | (id_ex.mem.wb.reg_write & hit_idex)
                  | (ex_mem.wb.reg_write & hit_exmem);
        fwd_a     = FWD_REGFILE;
        fwd_b     = FWD_REGFILE;
    end
`endif

    always_comb begin
        flush = id_ex.branch & ex_zero;
        stall = raw_stall & ~flush;
        take  = id_valid & ~stall & ~flush;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_ex  <= BUBBLE;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            id_ex  <= take ? dec : BUBBLE;
            ex_mem <= id_ex.mem;
            mem_wb <= ex_mem.wb;
        end
    end

    always_comb begin
        ex_reg_dst    = id_ex.reg_dst;
        ex_alu_src    = id_ex.alu_src;
        ex_alu_op     = id_ex.alu_op;
        illegal       = id_ex.illegal;
        mem_read      = ex_mem.mem_read;
        mem_write     = ex_mem.mem_write;
        wb_reg_write  = mem_wb.reg_write;
        wb_mem_to_reg = mem_wb.mem_to_reg;
        wb_dest       = mem_wb.dest;
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Randomized + directed bench for pipe_ctrl_unit with an instruction-level reference
// model; honours PIPE_CTRL_FWD_EN the same way the design does.
module tb_pipe_ctrl_unit;

    localparam int W = 22;

`ifdef PIPE_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;
    logic       ex_zero;
    logic       ex_reg_dst, ex_alu_src;
    logic [3:0] ex_alu_op;
    logic       mem_read, mem_write, wb_reg_write, wb_mem_to_reg;
    logic [4:0] wb_dest;
    logic       stall, flush, illegal;
    logic [1:0] fwd_a, fwd_b;

    always #5 clk = ~clk;

    pipe_ctrl_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .opcode(opcode), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd), .ex_zero(ex_zero),
        .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .mem_read(mem_read), .mem_write(mem_write), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_dest(wb_dest), .stall(stall), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .illegal(illegal)
    );

    typedef struct packed {
        bit       v;
        bit [5:0] op;
        bit [5:0] fn;
        bit [4:0] rs;
        bit [4:0] rt;
        bit [4:0] rd;
        bit       z;
    } item_t;

    logic [W-1:0] exp_q[$];
    item_t        pipe[$];   // [0]=EX, [1]=MEM, [2]=WB instruction (v=0 is a bubble)
    item_t        prog[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc    = 0;

    // ---------------- reference model ----------------
    function automatic bit legal(bit [5:0] op, bit [5:0] fn);
        case (op)
            6'd0:                    return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
            6'd35, 6'd43, 6'd4, 6'd8: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic bit ok(item_t e);
        return e.v && legal(e.op, e.fn);
    endfunction

    function automatic bit [4:0] dest_of(item_t e);
        if (!ok(e)) return 5'd0;
        return (e.op == 6'd0) ? e.rd : e.rt;
    endfunction

    function automatic bit writes(item_t e);
        return ok(e) && (e.op inside {6'd0, 6'd35, 6'd8}) && dest_of(e) != 5'd0;
    endfunction

    function automatic bit [3:0] alu_code(item_t e);
        if (!ok(e)) return 4'd0;
        if (e.op == 6'd4) return 4'b0110;
        if (e.op != 6'd0) return 4'b0010;
        case (e.fn)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic bit reads(item_t it, bit [4:0] r);
        if (!ok(it) || r == 5'd0) return 1'b0;
        return (it.rs == r) || ((it.op inside {6'd0, 6'd43, 6'd4}) && it.rt == r);
    endfunction

    function automatic bit [1:0] fwd_of(bit [4:0] src, item_t m, item_t w);
        if (src != 5'd0 && writes(m) && dest_of(m) == src) return 2'd2;
        if (src != 5'd0 && writes(w) && dest_of(w) == src) return 2'd1;
        return 2'd0;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input item_t it, input bit rst, output bit adv);
        item_t ex, mem, wb, nxt;
        bit st, fl, lu;
        bit [1:0] fa, fb;
        logic [W-1:0] e;
        id_valid = it.v; opcode = it.op; funct = it.fn;
        rs = it.rs; rt = it.rt; rd = it.rd; ex_zero = it.z;
        reset = !rst;
        if (rst) begin
            pipe = {};
            repeat (3) pipe.push_back('0);
        end
        ex = pipe[0]; mem = pipe[1]; wb = pipe[2];
        lu = ok(ex) && ex.op == 6'd35 && dest_of(ex) != 5'd0 && reads(it, dest_of(ex));
        if (FWD) begin
            st = lu;
            fa = fwd_of(ok(ex) ? ex.rs : 5'd0, mem, wb);
            fb = fwd_of(ok(ex) ? ex.rt : 5'd0, mem, wb);
        end else begin
            st = lu || (writes(ex) && reads(it, dest_of(ex)))
                    || (writes(mem) && reads(it, dest_of(mem)));
            fa = 2'd0;
            fb = 2'd0;
        end
        fl = ok(ex) && ex.op == 6'd4 && it.z;
        if (fl) st = 1'b0;
        e = {ok(ex) && ex.op == 6'd0, ok(ex) && (ex.op inside {6'd35, 6'd43, 6'd8}),
             alu_code(ex), ok(mem) && mem.op == 6'd35, ok(mem) && mem.op == 6'd43,
             writes(wb), ok(wb) && wb.op == 6'd35, dest_of(wb), st, fl, fa, fb,
             ex.v && !legal(ex.op, ex.fn)};
        exp_q.push_back(e);
        adv = rst || !st;
        if (!rst) begin
            nxt = it;
            nxt.z = 1'b0;
            if (!(it.v && !st && !fl)) nxt = '0;
            void'(pipe.pop_back());
            pipe.push_front(nxt);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic item_t mk(bit [5:0] op, bit [5:0] fn, bit [4:0] s, bit [4:0] t,
                                 bit [4:0] d, bit z);
        item_t i;
        i.v = 1'b1; i.op = op; i.fn = fn; i.rs = s; i.rt = t; i.rd = d; i.z = z;
        return i;
    endfunction

    task automatic idle(input int n);
        repeat (n) prog.push_back('0);
    endtask

    task automatic run_prog();
        bit adv;
        int guard = 0;
        while (prog.size() > 0 && guard < 5000) begin
            step(prog[0], 1'b0, adv);
            if (adv) void'(prog.pop_front());
            guard++;
        end
        if (prog.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL prog_drain actual %0d left required 0", prog.size());
            prog = {};
        end
    endtask

    function automatic item_t rand_item();
        item_t i;
        int k;
        bit [5:0] ops[7];
        ops = '{6'd0, 6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd63};
        k = $urandom_range(0, 6);
        i.op = ops[k];
        case ($urandom_range(0, 5))
            0: i.fn = 6'h20;
            1: i.fn = 6'h22;
            2: i.fn = 6'h24;
            3: i.fn = 6'h25;
            4: i.fn = 6'h2A;
            default: i.fn = 6'($urandom_range(0, 63));
        endcase
        i.v  = ($urandom_range(0, 9) != 0);
        i.rs = 5'($urandom_range(0, 7));
        i.rt = 5'($urandom_range(0, 7));
        i.rd = 5'($urandom_range(0, 7));
        i.z  = 1'($urandom_range(0, 1));
        return i;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {ex_reg_dst, ex_alu_src, ex_alu_op, mem_read, mem_write,
                         wb_reg_write, wb_mem_to_reg, wb_dest, stall, flush,
                         fwd_a, fwd_b, illegal};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL outputs cycle %0d actual %h required %h", cyc, act_v, exp_v);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit adv;
        reset = 1'b0; id_valid = 1'b0; opcode = '0; funct = '0;
        rs = '0; rt = '0; rd = '0; ex_zero = 1'b0;
        repeat (3) pipe.push_back('0);
        @(posedge clk);
        #1;
        step('0, 1'b1, adv);
        step('0, 1'b1, adv);
        idle(4);
        // load-use: LW r2,0(r1) ; ADD r3,r2,r4
        prog.push_back(mk(6'd35, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0));
        prog.push_back(mk(6'd0, 6'h20, 5'd2, 5'd4, 5'd3, 1'b0));
        idle(4);
        // ALU-ALU dependence: ADD r5,r1,r1 ; SUB r6,r5,r5
        prog.push_back(mk(6'd0, 6'h20, 5'd1, 5'd1, 5'd5, 1'b0));
        prog.push_back(mk(6'd0, 6'h22, 5'd5, 5'd5, 5'd6, 1'b0));
        idle(4);
        // taken branch while a load hazard is pending in ID
        prog.push_back(mk(6'd35, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0));
        prog.push_back(mk(6'd4, 6'd0, 5'd1, 5'd1, 5'd0, 1'b0));
        prog.push_back(mk(6'd0, 6'h20, 5'd2, 5'd4, 5'd3, 1'b1));
        idle(4);
        // unsupported opcode and unsupported funct
        prog.push_back(mk(6'd63, 6'd0, 5'd1, 5'd2, 5'd3, 1'b0));
        idle(4);
        prog.push_back(mk(6'd0, 6'h3F, 5'd1, 5'd2, 5'd3, 1'b0));
        idle(4);
        // ADDI r0 then readers of r0
        prog.push_back(mk(6'd8, 6'd0, 5'd1, 5'd0, 5'd0, 1'b0));
        prog.push_back(mk(6'd0, 6'h20, 5'd0, 5'd0, 5'd7, 1'b0));
        idle(4);
        // SW/SLT/OR/AND coverage
        prog.push_back(mk(6'd43, 6'd0, 5'd3, 5'd7, 5'd0, 1'b0));
        prog.push_back(mk(6'd0, 6'h2A, 5'd3, 5'd7, 5'd1, 1'b0));
        prog.push_back(mk(6'd0, 6'h25, 5'd1, 5'd3, 5'd2, 1'b0));
        prog.push_back(mk(6'd0, 6'h24, 5'd2, 5'd1, 5'd4, 1'b0));
        idle(2);
        prog.push_back(mk(6'd35, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0));
        prog.push_back(mk(6'd0, 6'h20, 5'd1, 5'd1, 5'd3, 1'b0));
        run_prog();
        // reset in the middle of a populated pipeline
        step('0, 1'b1, adv);
        idle(3);
        repeat (300) prog.push_back(rand_item());
        idle(4);
        run_prog();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain actual %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
